// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state encodings shared by alu_seq and its bench.
package alu_seq_pkg;

  localparam int ALU_FUNC_W = 3;

  typedef enum logic [ALU_FUNC_W-1:0] {
    ADD  = 3'b000,
    NAND = 3'b001,
    PASS = 3'b010,
    EQ   = 3'b011,
    SHL  = 3'b100,
    SHR  = 3'b101,
    MUL  = 3'b110,
    RSVD = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle.
// The product is exposed combinationally together with o_done so the
// caller can register the final step's result on the same edge.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign o_done     = r_active && (r_cnt == '0);
  assign o_product  = w_acc_next;

  // Load operands on start, then one shift-add step per cycle for WIDTH cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked single-result ALU with registered out/flags.
// Build option: define ALU_SEQ_MUL_EN to include the iterative multiplier
// (opcode 110); otherwise 110 is reported as illegal like 111.
//
// state | meaning
// IDLE  | no result held, ready to accept
// BUSY  | multiply in progress, not accepting
// DONE  | result valid, waiting for out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]      in1,
  input  logic [WIDTH-1:0]      in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  eq,
  output logic                  carry,
  output logic                  illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e r_state, w_next_state;

  logic [WIDTH-1:0] r_out;
  logic             r_eq;
  logic             r_carry;
  logic             r_illegal;

  logic               w_accept;
  logic               w_is_mul;
  logic [SHAMT_W-1:0] w_sh;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_eq;
  logic               w_carry;
  logic               w_illegal;

`ifdef ALU_SEQ_MUL_EN
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;

  assign w_is_mul = (func_e'(func) == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (in1),
    .i_b       (in2),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
`else
  assign w_is_mul = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign eq        = r_eq;
  assign carry     = r_carry;
  assign illegal   = r_illegal;

  assign w_sh  = in2[SHAMT_W-1:0];
  assign w_sum = {1'b0, in1} + {1'b0, in2};

  // Single-cycle datapath for every opcode except the iterative multiply.
  always_comb begin
    w_res     = '0;
    w_eq      = 1'b0;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    case (func_e'(func))
      ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      NAND: w_res = ~(in1 & in2);
      PASS: w_res = in1;
      EQ: begin
        w_res = in1;
        w_eq  = (in1 == in2);
      end
      SHL: w_res = in1 << w_sh;
      SHR: w_res = in1 >> w_sh;
      MUL: begin
`ifndef ALU_SEQ_MUL_EN
        w_illegal = 1'b1;
`endif
      end
      RSVD:    w_illegal = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a retire in DONE can take a new op in the same cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = w_is_mul ? BUSY : DONE;
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_done) w_next_state = DONE;
`else
        w_next_state = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) w_next_state = w_is_mul ? BUSY : DONE;
          else          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Result and flag registers: load at accept or on multiply completion, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out     <= '0;
      r_eq      <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_out     <= '0;
        r_eq      <= 1'b0;
        r_carry   <= 1'b0;
        r_illegal <= 1'b0;
      end else begin
        r_out     <= w_res;
        r_eq      <= w_eq;
        r_carry   <= w_carry;
        r_illegal <= w_illegal;
      end
    end
`ifdef ALU_SEQ_MUL_EN
    else if ((r_state == BUSY) && w_mul_done) begin
      r_out     <= w_product;
      r_eq      <= 1'b0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=16).
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        eq;
  logic        carry;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func      (func),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .eq        (eq),
    .carry     (carry),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; func = 3'b000; in1 = '0; in2 = '0; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rst_out: got %h want 0000", out); end
    n_checks++; if ({eq, carry, illegal} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {eq, carry, illegal}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_spurious_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_add;
    in_valid = 1'b1; func = 3'b000; in1 = 16'hFFFF; in2 = 16'h0001; out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL add_out: got %h want 0000", out); end
    n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b want 1", carry); end
    n_checks++; if ({eq, illegal} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b want 00", {eq, illegal}); end
    out_ready = 1'b1; in_valid = 1'b1; func = 3'b000; in1 = 16'h1234; in2 = 16'h0101;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out !== 16'h1335) begin n_fail++; $display("FAIL add2_out: got %h want 1335", out); end
    n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL add2_carry: got %b want 0", carry); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1; in_valid = 1'b1; func = 3'b011; in1 = 16'h1234; in2 = 16'h1234;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eq1_valid: got %b want 1", out_valid); end
    n_checks++; if (eq !== 1'b1) begin n_fail++; $display("FAIL eq1_eq: got %b want 1", eq); end
    n_checks++; if (out !== 16'h1234) begin n_fail++; $display("FAIL eq1_out: got %h want 1234", out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    in2 = 16'h1235;
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eq2_valid: got %b want 1", out_valid); end
    n_checks++; if (eq !== 1'b0) begin n_fail++; $display("FAIL eq2_eq: got %b want 0", eq); end
    n_checks++; if (out !== 16'h1234) begin n_fail++; $display("FAIL eq2_out: got %h want 1234", out); end
    func = 3'b010; in1 = 16'hABCD; in2 = 16'hABCD;
    tick();
    n_checks++; if (out !== 16'hABCD) begin n_fail++; $display("FAIL pass_out: got %h want abcd", out); end
    n_checks++; if ({eq, carry, illegal} !== 3'b000) begin n_fail++; $display("FAIL pass_flags: got %b want 000", {eq, carry, illegal}); end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_shift;
    out_ready = 1'b1; in_valid = 1'b1; func = 3'b100; in1 = 16'h0001; in2 = 16'hFFF3;
    tick();
    n_checks++; if (out !== 16'h0008) begin n_fail++; $display("FAIL shl_out: got %h want 0008", out); end
    func = 3'b101; in1 = 16'h8000; in2 = 16'h000F;
    tick();
    n_checks++; if (out !== 16'h0001) begin n_fail++; $display("FAIL shr_out: got %h want 0001", out); end
    func = 3'b101; in1 = 16'hF0F0; in2 = 16'h0014;
    tick();
    n_checks++; if (out !== 16'h0F0F) begin n_fail++; $display("FAIL shr2_out: got %h want 0f0f", out); end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_hold;
    out_ready = 1'b0; in_valid = 1'b1; func = 3'b001; in1 = 16'hF0F0; in2 = 16'hFF00;
    tick();
    func = 3'b000; in1 = 16'h0001; in2 = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out !== 16'h0FFF) begin n_fail++; $display("FAIL hold_out[%0d]: got %h want 0fff", i, out); end
      n_checks++; if ({eq, carry, illegal} !== 3'b000) begin n_fail++; $display("FAIL hold_flags[%0d]: got %b want 000", i, {eq, carry, illegal}); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out !== 16'h0FFF) begin n_fail++; $display("FAIL hold_final: got %h want 0fff", out); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_mul;
    out_ready = 1'b0; in_valid = 1'b1; func = 3'b110; in1 = 16'h0003; in2 = 16'h0005;
    tick();
`ifdef ALU_SEQ_MUL_EN
    func = 3'b000; in1 = 16'h0007; in2 = 16'h0007;
    for (int i = 1; i <= 16; i++) begin
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy_ready[%0d]: got %b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_busy_valid[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_valid: got %b want 1", out_valid); end
    n_checks++; if (out !== 16'h000F) begin n_fail++; $display("FAIL mul_out: got %h want 000f", out); end
    n_checks++; if ({eq, carry, illegal} !== 3'b000) begin n_fail++; $display("FAIL mul_flags: got %b want 000", {eq, carry, illegal}); end
    out_ready = 1'b1; in_valid = 1'b1; func = 3'b110; in1 = 16'hFFFF; in2 = 16'hFFFF;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul2_busy: got %b want 0", out_valid); end
    repeat (15) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul2_early: got %b want 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul2_valid: got %b want 1", out_valid); end
    n_checks++; if (out !== 16'h0001) begin n_fail++; $display("FAIL mul2_out: got %h want 0001", out); end
    out_ready = 1'b1; in_valid = 1'b1; func = 3'b110; in1 = 16'h0123; in2 = 16'h0100;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (16) tick();
    n_checks++; if (out !== 16'h2300) begin n_fail++; $display("FAIL mul3_out: got %h want 2300", out); end
`else
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL nomul_valid: got %b want 1", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL nomul_out: got %h want 0000", out); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL nomul_illegal: got %b want 1", illegal); end
    n_checks++; if ({eq, carry} !== 2'b00) begin n_fail++; $display("FAIL nomul_flags: got %b want 00", {eq, carry}); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_op;
    out_ready = 1'b0; in_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
    func = 3'b110; in1 = 16'h0003; in2 = 16'h0005;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
`else
    func = 3'b000; in1 = 16'h0001; in2 = 16'h0001;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out !== 16'h0002) begin n_fail++; $display("FAIL pre_rst_out: got %h want 0002", out); end
`endif
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL midrst_out: got %h want 0000", out); end
    n_checks++; if ({eq, carry, illegal} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {eq, carry, illegal}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_stale[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1; func = 3'b111; in1 = 16'h0005; in2 = 16'h0005;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rsvd_valid: got %b want 1", out_valid); end
    n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rsvd_out: got %h want 0000", out); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL rsvd_illegal: got %b want 1", illegal); end
    n_checks++; if ({eq, carry} !== 2'b00) begin n_fail++; $display("FAIL rsvd_flags: got %b want 00", {eq, carry}); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsvd_retire: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_shift();
    test_hold();
    test_mul();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
